mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the single unified instruction/data memory of the multicycle core. It shares the memory between the CPU port, used by fetch and LW/SW, and a loader port, used by the program loader or debug. The granted request is latched, driven to the memory for one enable cycle, the memory's fixed read latency is waited out, and completion is returned with a one-cycle `ready` pulse. It sits between the core's memory interface and the memory macro.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LAT`, 1: memory read latency in cycles, counted from the `mem_en` cycle to the cycle `mem_rdata` is valid. Legal range is LAT ≥ 1.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: reset, synchronous and active-low.
- `cpu_req`, `cpu_we`  in  1: CPU request; 1 = write.
- `cpu_addr`  in  AW; `cpu_wdata`  in  DW.
- `cpu_rdata`  out  DW; `cpu_ready`  out  1: CPU completion pulse.
- `ld_req`, `ld_we`  in  1; `ld_addr`  in  AW; `ld_wdata`  in  DW: loader request.
- `ld_rdata`  out  DW; `ld_ready`  out  1: loader completion pulse.
- `mem_en`, `mem_we`  out  1; `mem_addr`  out  AW; `mem_wdata`  out  DW: memory command.
- `mem_rdata`  in  DW: memory read data.
- `busy`  out  1: high in every state except IDLE.
- `grant_ld`  out  1: current or most recent grant went to the loader.

## Operation
- States:
  - IDLE: sample requests.
  - ACCESS: `mem_en`=1 for exactly one cycle.
  - WAIT: read latency.
  - DONE: `ready` pulse.
- IDLE:
  - If any request is high, arbitrate.
  - Latch the winner's `we`, `addr` and `wdata` into internal registers.
  - Set `grant_ld`, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration is round-robin.
  - With one requester, it wins.
  - With both high, the port not granted last wins.
- ACCESS: `mem_en`=1, with `mem_we`, `mem_addr` and `mem_wdata` taken from the latched registers.
  - Write: go to DONE.
  - Read: load the counter with LAT-1 and go to WAIT.
- WAIT:
  - If count ≠ 0, decrement.
  - If count = 0, capture `mem_rdata` into the granted port's rdata register and go to DONE.
- DONE:
  - Assert the `ready` of the granted port only, for one cycle.
  - Go to IDLE.
- Outside ACCESS, `mem_en`=0 and `mem_we`=0. `mem_addr`/`mem_wdata` hold their latched values.
- `cpu_rdata` and `ld_rdata` are separate registers. Each changes only on its own port's read capture and is held indefinitely otherwise.
- Requester rules:
  - Hold `req` high until `ready`.
  - Request inputs may change freely after the IDLE grant cycle, because the arbiter latches them.
  - A `req` still high in the IDLE cycle after `ready` is treated as a new transaction.
- A request deasserted before its grant is simply not served. No error is raised.
- Reset (`reset`=0 on a clock edge), in any state, including mid-transaction:
  - State goes to IDLE and the counter to 0.
  - `mem_en`, `mem_we`, `cpu_ready`, `ld_ready`, `busy` = 0.
  - `cpu_rdata`, `ld_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `grant_ld`=1, so the CPU wins the first contended arbitration.
  - An aborted transaction gets no `ready`.

## Timing
- Request high in IDLE at cycle t:
  - `mem_en` is high in cycle t+1.
  - Write: `ready` in cycle t+2.
  - Read: data captured in cycle t+1+LAT, `ready` and valid rdata in cycle t+2+LAT.
- Throughput: minimum one IDLE cycle between transactions.
  - Write every 3 cycles.
  - Read every LAT+3 cycles.
- Contended steady state: grants strictly alternate CPU/loader. Neither port waits more than one foreign transaction.
- `ready` is never asserted on both ports in the same cycle.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - Defined: the CPU always wins when both request. `grant_ld` still reports each grant, but arbitration ignores it. The loader may starve while the CPU requests continuously.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then CPU read only.
  - Setup: LAT=2, memory word 0x10 = 0xDEADBEEF.
  - Stimulus: `cpu_req`=1, `cpu_addr`=0x10 at t.
  - Required: `mem_en` at t+1 only; `cpu_ready` pulse at t+4; `cpu_rdata`=0xDEADBEEF; `ld_ready` stays 0.
- Loader write.
  - Stimulus: `ld_we`=1, `ld_addr`=0x20, `ld_wdata`=0x12345678 at t.
  - Required: `mem_en`=`mem_we`=1 with that address/data at t+1; `ld_ready` at t+2.
  - Check: a following CPU read of 0x20 returns 0x12345678.
- Contention.
  - Stimulus: both ports request reads continuously from reset for 6 transactions.
  - Required: grant order CPU, LD, CPU, LD, CPU, LD.
  - With `MEM_ARB_FIXED_PRIO_EN`: all 6 grants to the CPU.
- Back-to-back.
  - Stimulus: CPU holds `req` across its `ready`.
  - Required: second `mem_en` exactly 2 cycles after the first `ready`. `cpu_rdata` is unchanged between the captures.
- Reset mid-WAIT.
  - Stimulus: LAT=3, `reset`=0 for one edge during WAIT.
  - Required: next cycle in IDLE, all outputs at reset values, no `ready` pulse.
  - Check: a new request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/loader arbiter and access sequencer for the unified memory.
// Define MEM_ARB_FIXED_PRIO_EN to give the CPU fixed priority over the loader.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_ld
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          we_q;
  logic          req_any;
  logic          pick_ld;
  logic          cap;

  assign req_any = cpu_req | ld_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ld = ld_req & ~cpu_req;
`else
  // on a tie the loader wins only if the CPU was served last
  assign pick_ld = ld_req & (~cpu_req | ~grant_ld);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_any) state_n = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          state_n = DONE;
        end else begin
          cnt_n   = CNT_INIT;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cap     = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_ld  <= 1'b1;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        grant_ld  <= pick_ld;
        we_q      <= pick_ld ? ld_we : cpu_we;
        mem_addr  <= pick_ld ? ld_addr : cpu_addr;
        mem_wdata <= pick_ld ? ld_wdata : cpu_wdata;
      end
      if (cap) begin
        if (grant_ld) ld_rdata <= mem_rdata;
        else cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) & we_q;
  assign busy      = (state != IDLE);
  assign cpu_ready = (state == DONE) & ~grant_ld;
  assign ld_ready  = (state == DONE) & grant_ld;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random stimulus against a cycle-offset
// transaction model; honours MEM_ARB_FIXED_PRIO_EN when defined.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata, mem_wdata;
  logic [DW-1:0] cpu_rdata, ld_rdata, mem_rdata;
  logic          cpu_ready, ld_ready;
  logic          mem_en, mem_we, busy, grant_ld;

  bit            r_req [2];
  bit            r_we  [2];
  logic [31:0]   r_addr [2];
  logic [31:0]   r_wdata [2];

  assign cpu_req   = r_req[0];
  assign cpu_we    = r_we[0];
  assign cpu_addr  = r_addr[0];
  assign cpu_wdata = r_wdata[0];
  assign ld_req    = r_req[1];
  assign ld_we     = r_we[1];
  assign ld_addr   = r_addr[1];
  assign ld_wdata  = r_wdata[1];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ready(ld_ready),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .grant_ld(grant_ld)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA500_0000 | (i * 32'h0001_0101);
  endfunction

  // memory device with LAT-cycle read pipeline; junk when no read issued
  logic [31:0] mem  [256];
  logic [31:0] pipe [LAT];
  bit          loaded = 1'b0;
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : $urandom;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // reference model: transaction phase k counted from the grant cycle
  bit          m_act, m_we, m_port, m_gld;
  int          m_k, m_n;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [31:0] e_rd [2];
  logic [31:0] shadow [256];
  bit          fin [2];

  bit          o_en, o_we, o_busy, o_gld;
  bit          o_rdy [2];
  logic [31:0] o_addr, o_wdata, o_crd, o_lrd;

  task automatic model_check();
    bit acc, done;
    acc  = m_act && m_k == 1;
    done = m_act && m_k == m_n;
    chk("busy", busy, m_act);
    chk("mem_en", mem_en, acc);
    chk("mem_we", mem_we, acc && m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("grant_ld", grant_ld, m_gld);
    chk("cpu_ready", cpu_ready, done && !m_port);
    chk("ld_ready", ld_ready, done && m_port);
    chk("cpu_rdata", cpu_rdata, e_rd[0]);
    chk("ld_rdata", ld_rdata, e_rd[1]);
  endtask

  task automatic model_step();
    bit w;
    fin[0] = 1'b0;
    fin[1] = 1'b0;
    if (!reset) begin
      m_act   = 1'b0;
      m_gld   = 1'b1;
      m_addr  = '0;
      m_wdata = '0;
      e_rd[0] = '0;
      e_rd[1] = '0;
    end else if (m_act) begin
      if (!m_we && m_k == 1 + LAT) e_rd[m_port] = m_rd;
      if (m_k == m_n) begin
        m_act       = 1'b0;
        fin[m_port] = 1'b1;
      end else begin
        m_k++;
      end
    end else if (r_req[0] || r_req[1]) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      w = !r_req[0];
`else
      if (r_req[0] && r_req[1]) w = !m_gld;
      else w = r_req[1];
`endif
      m_we    = r_we[w];
      m_addr  = r_addr[w];
      m_wdata = r_wdata[w];
      m_rd    = shadow[m_addr[9:2]];
      if (m_we) shadow[m_addr[9:2]] = m_wdata;
      m_act  = 1'b1;
      m_k    = 1;
      m_n    = m_we ? 2 : 2 + LAT;
      m_port = w;
      m_gld  = w;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    o_en     = mem_en;
    o_we     = mem_we;
    o_busy   = busy;
    o_gld    = grant_ld;
    o_rdy[0] = cpu_ready;
    o_rdy[1] = ld_ready;
    o_addr   = mem_addr;
    o_wdata  = mem_wdata;
    o_crd    = cpu_rdata;
    o_lrd    = ld_rdata;
    if (chk_en) model_check();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [31:0] cap_addr, cap_wdata;
  bit          cap_we;

  // single request issued in the current (idle) cycle; offsets from it
  task automatic do_txn(input int p, input bit we,
                        input logic [31:0] a, input logic [31:0] d,
                        output int t_en, output int t_rdy,
                        output int n_en, output int n_oth);
    r_req[p]   = 1'b1;
    r_we[p]    = we;
    r_addr[p]  = a;
    r_wdata[p] = d;
    t_en  = -1;
    t_rdy = -1;
    n_en  = 0;
    n_oth = 0;
    for (int i = 0; i < 20 && t_rdy < 0; i++) begin
      tick();
      if (o_en) begin
        n_en++;
        if (t_en < 0) begin
          t_en      = i;
          cap_we    = o_we;
          cap_addr  = o_addr;
          cap_wdata = o_wdata;
        end
      end
      if (o_rdy[1-p]) n_oth++;
      if (o_rdy[p]) begin
        t_rdy    = i;
        r_req[p] = 1'b0;
      end
    end
  endtask

  task automatic new_payload(input int p);
    r_we[p]    = 1'($urandom_range(1));
    r_addr[p]  = {22'd0, 8'($urandom_range(255)), 2'b00};
    r_wdata[p] = $urandom;
  endtask

  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      if (fin[p]) begin
        if ($urandom_range(1) == 1) new_payload(p);
        else r_req[p] = 1'b0;
      end else if (m_act && m_port == 1'(p)) begin
        new_payload(p);
      end else if (r_req[p]) begin
        if ($urandom_range(19) == 0) r_req[p] = 1'b0;
      end else if ($urandom_range(9) < 4) begin
        r_req[p] = 1'b1;
        new_payload(p);
      end
    end
  endtask

  initial begin
    int te, tr, ne, no, seen, nr, unstable;
    int e2, r1, r2, n_en2, n_rdy2;
    logic [31:0] held;
    bit gq[$];

    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      r_req[p]   = 1'b0;
      r_we[p]    = 1'b0;
      r_addr[p]  = '0;
      r_wdata[p] = '0;
    end
    reset = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_mem_en", o_en, 0);
    chk("rst_grant_ld", o_gld, 1);
    chk("rst_cpu_rdata", o_crd, 0);
    chk("rst_mem_addr", o_addr, 0);
    reset = 1'b1;
    tick();

    do_txn(0, 1'b0, 32'h10, 32'h0, te, tr, ne, no);
    chk("rd_en_cycle", te, 1);
    chk("rd_en_count", ne, 1);
    chk("rd_ready_cycle", tr, 2 + LAT);
    chk("rd_data", o_crd, 32'hDEADBEEF);
    chk("rd_ld_ready", no, 0);

    do_txn(1, 1'b1, 32'h20, 32'h12345678, te, tr, ne, no);
    chk("wr_en_cycle", te, 1);
    chk("wr_mem_we", cap_we, 1);
    chk("wr_mem_addr", cap_addr, 32'h20);
    chk("wr_mem_wdata", cap_wdata, 32'h12345678);
    chk("wr_ready_cycle", tr, 2);
    chk("wr_cpu_ready", no, 0);

    do_txn(0, 1'b0, 32'h20, 32'h0, te, tr, ne, no);
    chk("rb_ready_cycle", tr, 2 + LAT);
    chk("rb_data", o_crd, 32'h12345678);

    // contention from reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    r_req[0]  = 1'b1;
    r_we[0]   = 1'b0;
    r_addr[0] = 32'h10;
    r_req[1]  = 1'b1;
    r_we[1]   = 1'b0;
    r_addr[1] = 32'h20;
    for (int i = 0; i < 80 && gq.size() < 6; i++) begin
      tick();
      if (o_en) gq.push_back(o_gld);
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!o_busy) break;
    end
    chk("ct_grants", gq.size(), 6);
    for (int i = 0; i < gq.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk($sformatf("ct_grant%0d", i), gq[i], 0);
`else
      chk($sformatf("ct_grant%0d", i), gq[i], i % 2);
`endif
    end

    // back-to-back CPU reads, address switched after first ready
    r_req[0]  = 1'b1;
    r_we[0]   = 1'b0;
    r_addr[0] = 32'h10;
    e2 = -1; r1 = -1; r2 = -1;
    n_en2 = 0; n_rdy2 = 0; unstable = 0; held = '0;
    for (int i = 0; i < 40 && r2 < 0; i++) begin
      tick();
      if (o_en) begin
        n_en2++;
        if (n_en2 == 2) e2 = i;
      end
      if (o_rdy[0]) begin
        n_rdy2++;
        if (n_rdy2 == 1) begin
          r1        = i;
          held      = o_crd;
          r_addr[0] = 32'h20;
        end else begin
          r2       = i;
          r_req[0] = 1'b0;
        end
      end else if (n_rdy2 == 1 && o_crd !== held) begin
        unstable++;
      end
    end
    chk("b2b_gap", e2 - r1, 2);
    chk("b2b_first", held, 32'hDEADBEEF);
    chk("b2b_hold", unstable, 0);
    chk("b2b_second_lat", r2 - e2, 1 + LAT);
    chk("b2b_second", o_crd, 32'h12345678);

    // reset during WAIT
    r_req[0]  = 1'b1;
    r_we[0]   = 1'b0;
    r_addr[0] = 32'h20;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (o_en) seen = 1;
    end
    chk("mw_en_seen", seen, 1);
    tick();
    reset    = 1'b0;
    r_req[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mw_busy", o_busy, 0);
    chk("mw_mem_en", o_en, 0);
    chk("mw_grant_ld", o_gld, 1);
    chk("mw_cpu_rdata", o_crd, 0);
    chk("mw_ld_rdata", o_lrd, 0);
    chk("mw_mem_addr", o_addr, 0);
    chk("mw_mem_wdata", o_wdata, 0);
    chk("mw_cpu_ready", o_rdy[0], 0);
    nr = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_rdy[0] || o_rdy[1]) nr++;
    end
    chk("mw_no_ready", nr, 0);
    do_txn(0, 1'b0, 32'h20, 32'h0, te, tr, ne, no);
    chk("mw_new_ready", tr, 2 + LAT);
    chk("mw_new_data", o_crd, 32'h12345678);

    for (int c = 0; c < 2000; c++) begin
      tick();
      drive_random();
    end
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!o_busy && !m_act) break;
    end
    chk("drain_idle", o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
